mc_controller: RTL and testbench
================================

# mc_controller

Main control unit of the multicycle MIPS core. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback, driving every datapath enable and mux select. It also decodes the 3-bit `ALUControl` code that selects the shared `alu` operation each cycle. It takes branch feedback from the ALU `Zero` flag and sits between the instruction register and the datapath.

## Interface
- `STATE_W`, default 4: state register width; must hold 12 states.
- `clk`  in  1  single clock; all state changes occur on the rising edge.
- `reset`  in  1  synchronous, active-high; state = FETCH on the first rising edge with `reset`=1.
- `Op`  in  6  instruction opcode, IR[31:26].
- `Funct`  in  6  function field, IR[5:0].
- `Zero`  in  1  ALU zero flag, combinational from the current ALU result.
- `IorD`, `ALUSrcA`, `RegDst`, `MemtoReg`  out  1  datapath mux selects.
- `ALUSrcB`  out  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2.
- `PCSrc`  out  2  00=ALUResult, 01=ALUOut, 10=jump target.
- `MemWrite`, `IRWrite`, `RegWrite`  out  1  write enables.
- `PCEn`  out  1  PC register enable.
- `ALUControl`  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.

## Operation
- Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BEQ, ADDIEXEC, ADDIWB, JUMP.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (LW/SW), EXECUTE (RTYPE), BEQ, ADDIEXEC, JUMP; any other opcode→FETCH.
  - MEMADR→MEMRD (LW) or MEMWR (SW).
  - MEMRD→MEMWB.
  - EXECUTE→ALUWB.
  - ADDIEXEC→ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BEQ, JUMP→FETCH.
- Per-state outputs. Every output not listed is 0; ALUOp is an internal 2-bit code.
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - MEMADR, ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: IorD=1.
  - MEMWR: IorD=1, MemWrite=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
  - JUMP: PCSrc=10, PCWrite=1.
- PCEn = PCWrite | (Branch & Zero).
- ALU decode:
  - ALUOp 00→010; ALUOp 01→110.
  - ALUOp 10 by Funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, any other Funct→010.
  - ALUOp 11 never occurs; it decodes to 010.
- Unsupported opcode or funct performs no architectural write beyond the FETCH PC+4 update.

## Timing
- Outputs are combinational from the state register and `Op`/`Funct`; there is no output register. `PCEn` depends combinationally on `Zero`.
- Reset:
  - While `reset`=1, `MemWrite`, `IRWrite`, `RegWrite` and `PCEn` are forced to 0.
  - Mux selects and `ALUControl` show FETCH values (`ALUControl`=010, `ALUSrcB`=01).
  - The first FETCH write occurs in the cycle after `reset` deasserts.
- Reset mid-instruction abandons it; no partial write enable is asserted after the reset edge.
- Cycles per instruction, from FETCH to the next FETCH: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, unsupported opcode 2.
- `Op`/`Funct` are sampled from the IR, which is stable from DECODE onward.

## Structure
- Shared package `mc_pkg` holds:
  - state encoding constants;
  - opcode and funct constants;
  - ALUControl codes;
  - ALUOp codes.
  These are shared with the `alu` bench and the datapath.
- One sub-module, `alu_decoder`: inputs ALUOp and `Funct`, output `ALUControl`; purely combinational.
- The top level holds the state register, next-state logic, output decode and the `PCEn` gate.

## Test plan
- Reset then LW (`Op`=100011) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. Check `IRWrite`=1 only in FETCH, `IorD`=1 in MEMRD, and `RegWrite`=1 with `MemtoReg`=1 in MEMWB.
- RTYPE with each `Funct` of 100000/100010/100100/100101/101010 → `ALUControl` in EXECUTE is 010/110/000/001/111 respectively. ALUWB asserts `RegDst`=1 and `RegWrite`=1.
- BEQ with `Zero`=1 → `PCEn`=1 and `PCSrc`=01 in the BEQ state. Repeating with `Zero`=0 → `PCEn`=0. Both return to FETCH after 3 cycles.
- SW then J → `MemWrite`=1 only in MEMWR. J asserts `PCSrc`=10 and `PCEn`=1 for exactly one cycle.
- `Op`=111111 → DECODE→FETCH, with no `RegWrite` or `MemWrite` asserted. The next instruction executes normally.
- Reset asserted in MEMWR of an SW → `MemWrite`=0 in that cycle. State = FETCH on the next edge; all write enables are 0 until `reset` drops.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// FSM states, opcodes, funct codes, ALUOp and ALUControl values.
package mc_pkg;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMRD    = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWR    = 4'd5;
   localparam logic [3:0] S_EXECUTE  = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_BEQ      = 4'd8;
   localparam logic [3:0] S_ADDIEXEC = 4'd9;
   localparam logic [3:0] S_ADDIWB   = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALUC_AND = 3'b000;
   localparam logic [2:0] ALUC_OR  = 3'b001;
   localparam logic [2:0] ALUC_ADD = 3'b010;
   localparam logic [2:0] ALUC_SUB = 3'b110;
   localparam logic [2:0] ALUC_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALUOp and the R-type funct field
// onto the 3-bit ALUControl code of the shared ALU.
module alu_decoder
   import mc_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [5:0] Funct,
   output logic [2:0] ALUControl
);

   always_comb begin
      ALUControl = ALUC_ADD;
      case (ALUOp)
         ALUOP_SUB: ALUControl = ALUC_SUB;
         ALUOP_FUNCT: begin
            case (Funct)
               FN_SUB:  ALUControl = ALUC_SUB;
               FN_AND:  ALUControl = ALUC_AND;
               FN_OR:   ALUControl = ALUC_OR;
               FN_SLT:  ALUControl = ALUC_SLT;
               default: ALUControl = ALUC_ADD;
            endcase
         end
         default: ALUControl = ALUC_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM of the multicycle MIPS core: steps each
// instruction through its states and drives datapath controls.
module mc_controller #(
   parameter int STATE_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       IorD,
   output logic       ALUSrcA,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       PCEn,
   output logic [2:0] ALUControl
);

   import mc_pkg::*;

   localparam logic [STATE_W-1:0] L_FETCH    = STATE_W'(S_FETCH);
   localparam logic [STATE_W-1:0] L_DECODE   = STATE_W'(S_DECODE);
   localparam logic [STATE_W-1:0] L_MEMADR   = STATE_W'(S_MEMADR);
   localparam logic [STATE_W-1:0] L_MEMRD    = STATE_W'(S_MEMRD);
   localparam logic [STATE_W-1:0] L_MEMWB    = STATE_W'(S_MEMWB);
   localparam logic [STATE_W-1:0] L_MEMWR    = STATE_W'(S_MEMWR);
   localparam logic [STATE_W-1:0] L_EXECUTE  = STATE_W'(S_EXECUTE);
   localparam logic [STATE_W-1:0] L_ALUWB    = STATE_W'(S_ALUWB);
   localparam logic [STATE_W-1:0] L_BEQ      = STATE_W'(S_BEQ);
   localparam logic [STATE_W-1:0] L_ADDIEXEC = STATE_W'(S_ADDIEXEC);
   localparam logic [STATE_W-1:0] L_ADDIWB   = STATE_W'(S_ADDIWB);
   localparam logic [STATE_W-1:0] L_JUMP     = STATE_W'(S_JUMP);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_next;
   logic [STATE_W-1:0] w_cur;
   logic [1:0]         w_aluop;
   logic               w_memwrite;
   logic               w_irwrite;
   logic               w_regwrite;
   logic               w_pcwrite;
   logic               w_branch;

   always_ff @(posedge clk) begin
      if (reset) r_state <= L_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = L_FETCH;
      case (r_state)
         L_FETCH: w_next = L_DECODE;
         L_DECODE: begin
            case (Op)
               OP_LW, OP_SW: w_next = L_MEMADR;
               OP_RTYPE:     w_next = L_EXECUTE;
               OP_BEQ:       w_next = L_BEQ;
               OP_ADDI:      w_next = L_ADDIEXEC;
               OP_J:         w_next = L_JUMP;
               default:      w_next = L_FETCH;
            endcase
         end
         L_MEMADR:   w_next = (Op == OP_SW) ? L_MEMWR : L_MEMRD;
         L_MEMRD:    w_next = L_MEMWB;
         L_EXECUTE:  w_next = L_ALUWB;
         L_ADDIEXEC: w_next = L_ADDIWB;
         default:    w_next = L_FETCH;
      endcase
   end

   // Reset presents FETCH mux settings; enables are masked below.
   assign w_cur = reset ? L_FETCH : r_state;

   always_comb begin
      IorD       = 1'b0;
      ALUSrcA    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcB    = 2'b00;
      PCSrc      = 2'b00;
      w_aluop    = ALUOP_ADD;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_regwrite = 1'b0;
      w_pcwrite  = 1'b0;
      w_branch   = 1'b0;
      case (w_cur)
         L_FETCH: begin
            ALUSrcB   = 2'b01;
            w_irwrite = 1'b1;
            w_pcwrite = 1'b1;
         end
         L_DECODE: ALUSrcB = 2'b11;
         L_MEMADR, L_ADDIEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         L_MEMRD: IorD = 1'b1;
         L_MEMWR: begin
            IorD       = 1'b1;
            w_memwrite = 1'b1;
         end
         L_MEMWB: begin
            MemtoReg   = 1'b1;
            w_regwrite = 1'b1;
         end
         L_EXECUTE: begin
            ALUSrcA = 1'b1;
            w_aluop = ALUOP_FUNCT;
         end
         L_ALUWB: begin
            RegDst     = 1'b1;
            w_regwrite = 1'b1;
         end
         L_ADDIWB: w_regwrite = 1'b1;
         L_BEQ: begin
            ALUSrcA  = 1'b1;
            w_aluop  = ALUOP_SUB;
            PCSrc    = 2'b01;
            w_branch = 1'b1;
         end
         L_JUMP: begin
            PCSrc     = 2'b10;
            w_pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   assign MemWrite = w_memwrite & ~reset;
   assign IRWrite  = w_irwrite & ~reset;
   assign RegWrite = w_regwrite & ~reset;
   assign PCEn     = (w_pcwrite | (w_branch & Zero)) & ~reset;

   alu_decoder u_alu_decoder (
      .ALUOp      (w_aluop),
      .Funct      (Funct),
      .ALUControl (ALUControl)
   );

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected control
// vectors derived from instruction-level behaviour.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] Op = 6'd0;
   logic [5:0] Funct = 6'd0;
   logic       Zero = 1'b0;
   logic       IorD, ALUSrcA, RegDst, MemtoReg;
   logic [1:0] ALUSrcB, PCSrc;
   logic       MemWrite, IRWrite, RegWrite, PCEn;
   logic [2:0] ALUControl;

   mc_controller #(.STATE_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .Op         (Op),
      .Funct      (Funct),
      .Zero       (Zero),
      .IorD       (IorD),
      .ALUSrcA    (ALUSrcA),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .ALUSrcB    (ALUSrcB),
      .PCSrc      (PCSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .PCEn       (PCEn),
      .ALUControl (ALUControl)
   );

   always #5 clk = ~clk;

   typedef logic [14:0] vec_t;

   vec_t  q[$];
   string tag_q[$];
   string cur_tag = "reset";
   int    n_chk = 0;
   int    n_pass = 0;
   vec_t  w_act;

   assign w_act = {IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc,
                   MemWrite, IRWrite, RegWrite, PCEn, ALUControl};

   function automatic vec_t mk(input logic iord, input logic srca,
                               input logic rdst, input logic m2r,
                               input logic [1:0] srcb, input logic [1:0] pcs,
                               input logic mw, input logic irw,
                               input logic rw, input logic pce,
                               input logic [2:0] alc);
      return {iord, srca, rdst, m2r, srcb, pcs, mw, irw, rw, pce, alc};
   endfunction

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010;

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic int cpi(input logic [5:0] op);
      case (op)
         LW:      return 5;
         SW, RT, AI: return 4;
         BQ, JJ:  return 3;
         default: return 2;
      endcase
   endfunction

   // Controls seen in step k (0 = fetch) of an instruction.
   function automatic vec_t expect_step(input logic [5:0] op,
                                        input logic [5:0] f,
                                        input int k, input logic z);
      if (k == 0) return mk(0,0,0,0,2'b01,2'b00,0,1,0,1,3'b010);
      if (k == 1) return mk(0,0,0,0,2'b11,2'b00,0,0,0,0,3'b010);
      case (op)
         LW, SW, AI: begin
            if (k == 2) return mk(0,1,0,0,2'b10,2'b00,0,0,0,0,3'b010);
            if (op == AI) return mk(0,0,0,0,2'b00,2'b00,0,0,1,0,3'b010);
            if (op == SW) return mk(1,0,0,0,2'b00,2'b00,1,0,0,0,3'b010);
            if (k == 3) return mk(1,0,0,0,2'b00,2'b00,0,0,0,0,3'b010);
            return mk(0,0,0,1,2'b00,2'b00,0,0,1,0,3'b010);
         end
         RT: begin
            if (k == 2) return mk(0,1,0,0,2'b00,2'b00,0,0,0,0,funct_alu(f));
            return mk(0,0,1,0,2'b00,2'b00,0,0,1,0,3'b010);
         end
         BQ: return mk(0,1,0,0,2'b00,2'b01,0,0,0,z,3'b110);
         default: return mk(0,0,0,0,2'b00,2'b10,0,0,0,1,3'b010);
      endcase
   endfunction

   function automatic vec_t reset_vec();
      return mk(0,0,0,0,2'b01,2'b00,0,0,0,0,3'b010);
   endfunction

   // One instruction; zmode<0 randomizes Zero; rst_at>=0 injects reset.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                            input int zmode, input int rst_at);
      for (int k = 0; k < cpi(op); k++) begin
         @(posedge clk);
         #1;
         Op = op;
         Funct = f;
         Zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         cur_tag = $sformatf("op=%b f=%b k=%0d", op, f, k);
         if (k == rst_at) begin
            reset = 1'b1;
            q.push_back(reset_vec());
            tag_q.push_back({cur_tag, " rst"});
            @(posedge clk);
            #1;
            q.push_back(reset_vec());
            tag_q.push_back({cur_tag, " rst_hold"});
            return;
         end
         reset = 1'b0;
         q.push_back(expect_step(op, f, k, Zero));
         tag_q.push_back(cur_tag);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         vec_t  e;
         string t;
         e = q.pop_front();
         t = tag_q.pop_front();
         n_chk++;
         if (w_act === e) n_pass++;
         else $display("FAIL ctrl[%s] actual=%b required=%b", t, w_act, e);
      end
   end

   initial begin
      logic [5:0] ops[7];
      logic [5:0] fns[5];
      logic [5:0] op, f;
      int         ra;
      ops = '{LW, SW, RT, BQ, AI, JJ, 6'b111111};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

      reset = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         Zero = 1'($urandom_range(0, 1));
         q.push_back(reset_vec());
         tag_q.push_back("reset");
      end

      run_instr(LW, 6'd0, -1, -1);
      for (int i = 0; i < 5; i++) run_instr(RT, fns[i], -1, -1);
      run_instr(RT, 6'b000111, -1, -1);
      run_instr(BQ, 6'd0, 1, -1);
      run_instr(BQ, 6'd0, 0, -1);
      run_instr(SW, 6'd0, -1, -1);
      run_instr(JJ, 6'd0, -1, -1);
      run_instr(6'b111111, 6'd0, -1, -1);
      run_instr(AI, 6'd0, -1, -1);
      run_instr(SW, 6'd0, -1, 3);
      run_instr(LW, 6'd0, -1, -1);

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 7) == 0) op = 6'($urandom);
         else op = ops[$urandom_range(0, 6)];
         if ($urandom_range(0, 3) == 0) f = 6'($urandom);
         else f = fns[$urandom_range(0, 4)];
         ra = ($urandom_range(0, 9) == 0) ? $urandom_range(0, cpi(op) - 1) : -1;
         run_instr(op, f, -1, ra);
      end

      repeat (3) @(negedge clk);
      n_chk++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain actual=%0d required=0 pending", q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
